pc_if_pipe: RTL and testbench
=============================

Name: pc_if_pipe

Overview:
- Fetch-side sequential stage of the pipelined CPU: owns the program counter and the IF/ID pipeline register.
- Drives pc_o to the 32-bit PC adder (src1 = pc_o, src2 = 4) and consumes its sum as pc_plus4_i.
- Selects the next PC from sequential, branch redirect or hold. Captures the instruction-memory word into IF/ID, with stall, flush and performance counters.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating stall/flush counters.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pc_plus4_i  in  32  PC adder sum (pc_o + 4).
- branch_target_i  in  32  redirect target from EX/MEM.
- branch_taken_i  in  1  redirect request; flushes IF/ID.
- stall_i  in  1  hazard-unit hold (load-use).
- instr_i  in  32  instruction memory read data at address pc_o (combinational read).
- pc_o  out  32  current PC; feeds PC adder and instruction memory.
- ifid_pc4_o  out  32  IF/ID latched PC+4.
- ifid_instr_o  out  32  IF/ID latched instruction.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- stalled_o  out  1  high while FSM is in HOLD.
- misalign_o  out  1  sticky: a redirect target had bits [1:0] != 0.
- stall_cnt_o  out  CNT_W  saturating count of stalled edges.
- flush_cnt_o  out  CNT_W  saturating count of flushes.

Behaviour:
- Reset (rst_i=1 at edge, any state):
  - pc_o=PC_RESET, ifid_pc4_o=0, ifid_instr_o=0 (NOP), ifid_valid_o=0.
  - stalled_o=0, misalign_o=0, both counters=0, FSM=BOOT.
  - Reset overrides every other input, including mid-stall and mid-branch.
- FSM states: BOOT, RUN, HOLD.
- BOOT:
  - The next edge moves to RUN and changes nothing else.
  - pc_o is held and ifid_valid_o stays 0; branch_taken_i and stall_i are ignored.
  - Result: exactly one bubble after reset release.
- Per-edge priority in RUN/HOLD: rst_i > branch_taken_i > stall_i > advance.
- Flush (branch_taken_i=1, in RUN or HOLD):
  - pc_o <= {branch_target_i[31:2],2'b00}.
  - ifid_instr_o <= 0, ifid_pc4_o <= 0, ifid_valid_o <= 0.
  - FSM <= RUN and flush_cnt_o += 1.
  - If branch_target_i[1:0] != 0, misalign_o <= 1. It stays set until reset.
  - A branch coincident with stall_i flushes and does not stall; stall_cnt_o does not increment.
- Stall (stall_i=1, no branch):
  - pc_o and all IF/ID outputs are held.
  - FSM <= HOLD and stall_cnt_o += 1.
- Advance (no branch, no stall):
  - pc_o <= pc_plus4_i, ifid_pc4_o <= pc_plus4_i, ifid_instr_o <= instr_i, ifid_valid_o <= 1.
  - FSM <= RUN.
  - Leaving HOLD performs the advance on that same edge.
- stalled_o = (FSM==HOLD), registered.
- Latency: an instruction presented on instr_i for pc_o=P appears on ifid_instr_o, with ifid_pc4_o=P+4, one edge later.
- Arithmetic: PC wrap-around is modular. pc_plus4_i=0 from pc_o=32'hFFFF_FFFC is accepted without a flag. pc_o[1:0] is always 00.
- Counters saturate at all-ones and never wrap.
- No combinational path from any input to pc_o.

Test Plan:
- Reset/boot:
  - Stimulus: rst_i high 2 edges, then low; instr_i=32'h2001_0005.
  - Required: pc_o=0, ifid_valid_o=0 for the first edge after release. Next edge: pc_o=4, ifid_instr_o=32'h2001_0005, ifid_pc4_o=4, ifid_valid_o=1.
- Sequential run:
  - Stimulus: 4 advance edges from pc_o=0.
  - Required: pc_o steps 4,8,12,16; ifid_pc4_o lags by one edge; stall_cnt_o=flush_cnt_o=0.
- Stall:
  - Stimulus: at pc_o=8, stall_i=1 for 3 edges, then 0.
  - Required: pc_o=8 and IF/ID unchanged for 3 edges, stalled_o=1, stall_cnt_o=3. On release: pc_o=12, stalled_o=0.
- Branch during stall:
  - Stimulus: stall_i=1 and branch_taken_i=1 with branch_target_i=32'h0000_0040.
  - Required: pc_o=32'h40, ifid_valid_o=0, ifid_instr_o=0, flush_cnt_o=1, stall_cnt_o unchanged, stalled_o=0.
- Misaligned target and wrap:
  - Stimulus: branch_target_i=32'hFFFF_FFFE, then one advance with pc_plus4_i=0.
  - Required: pc_o=32'hFFFF_FFFC and misalign_o=1, then pc_o=0 with misalign_o still 1.
- Saturation and mid-operation reset:
  - Stimulus: force 65537 stall edges, then assert rst_i during stall.
  - Required: stall_cnt_o=16'hFFFF; after reset, all outputs equal their reset values and FSM=BOOT.

Source files
------------

// File: rtl/pc_if_pipe.sv
// pc_if_pipe: program counter and IF/ID pipeline register for the fetch stage.
// Chooses the next PC (sequential, branch redirect or hold), captures the fetched
// instruction into IF/ID and keeps saturating stall/flush event counters.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_BOOT | first edge after reset; inserts one bubble, ignores inputs
// ST_RUN  | normal fetch; flush, stall or advance on each edge
// ST_HOLD | hazard hold in progress; PC and IF/ID frozen
module pc_if_pipe #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      pc_plus4_i,
   input  logic [31:0]      branch_target_i,
   input  logic             branch_taken_i,
   input  logic             stall_i,
   input  logic [31:0]      instr_i,
   output logic [31:0]      pc_o,
   output logic [31:0]      ifid_pc4_o,
   output logic [31:0]      ifid_instr_o,
   output logic             ifid_valid_o,
   output logic             stalled_o,
   output logic             misalign_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t state;
   state_t state_nxt;
   logic   do_flush;
   logic   do_stall;
   logic   do_adv;

   // State register; reset always returns to BOOT.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-edge action decode: branch beats stall beats advance.
   always_comb begin
      state_nxt = state;
      do_flush  = 1'b0;
      do_stall  = 1'b0;
      do_adv    = 1'b0;
      case (state)
         ST_BOOT: begin
            state_nxt = ST_RUN;
         end
         default: begin
            if (branch_taken_i) begin
               do_flush  = 1'b1;
               state_nxt = ST_RUN;
            end else if (stall_i) begin
               do_stall  = 1'b1;
               state_nxt = ST_HOLD;
            end else begin
               do_adv    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
      endcase
   end

   assign stalled_o = (state == ST_HOLD);

   // PC and IF/ID register; the PC is always loaded word-aligned.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_o         <= PC_RESET;
         ifid_pc4_o   <= 32'h0;
         ifid_instr_o <= 32'h0;
         ifid_valid_o <= 1'b0;
      end else if (do_flush) begin
         pc_o         <= {branch_target_i[31:2], 2'b00};
         ifid_pc4_o   <= 32'h0;
         ifid_instr_o <= 32'h0;
         ifid_valid_o <= 1'b0;
      end else if (do_adv) begin
         pc_o         <= {pc_plus4_i[31:2], 2'b00};
         ifid_pc4_o   <= pc_plus4_i;
         ifid_instr_o <= instr_i;
         ifid_valid_o <= 1'b1;
      end
   end

   // Sticky misaligned-redirect flag, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         misalign_o <= 1'b0;
      end else if (do_flush && (branch_target_i[1:0] != 2'b00)) begin
         misalign_o <= 1'b1;
      end
   end

   // Saturating event counters; they stick at all-ones rather than wrap.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (do_stall && (stall_cnt_o != CNT_MAX)) begin
            stall_cnt_o <= stall_cnt_o + CNT_ONE;
         end
         if (do_flush && (flush_cnt_o != CNT_MAX)) begin
            flush_cnt_o <= flush_cnt_o + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pc_if_pipe.sv
// tb_pc_if_pipe: directed stimulus against a behavioural fetch-stage model,
// plus literal expectations at the key points of each scenario.
module tb_pc_if_pipe;

   localparam int CNT_W = 16;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic        clk;
   logic        rst;
   logic [31:0] pc_plus4;
   logic [31:0] br_tgt;
   logic        br_taken;
   logic        stall;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] ifid_pc4;
   logic [31:0] ifid_instr;
   logic        ifid_valid;
   logic        stalled;
   logic        misalign;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   // behavioural model state
   logic [31:0] m_pc, m_pc4, m_instr;
   bit          m_valid, m_hold, m_boot, m_mis;
   int          m_scnt, m_fcnt;

   function automatic logic [31:0] imem(input logic [31:0] a);
      if (a == 32'h0) return 32'h2001_0005;
      return {a[15:0], 16'h0013} ^ 32'h00A0_0000;
   endfunction

   // external PC adder and combinational instruction memory
   assign pc_plus4 = pc + 32'd4;
   assign instr    = imem(pc);

   pc_if_pipe #(.PC_RESET(32'h0000_0000), .CNT_W(CNT_W)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .pc_plus4_i     (pc_plus4),
      .branch_target_i(br_tgt),
      .branch_taken_i (br_taken),
      .stall_i        (stall),
      .instr_i        (instr),
      .pc_o           (pc),
      .ifid_pc4_o     (ifid_pc4),
      .ifid_instr_o   (ifid_instr),
      .ifid_valid_o   (ifid_valid),
      .stalled_o      (stalled),
      .misalign_o     (misalign),
      .stall_cnt_o    (stall_cnt),
      .flush_cnt_o    (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model update: one edge of the fetch stage from the inputs applied
   always @(posedge clk) begin
      if (rst) begin
         m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0;
         m_valid = 0; m_hold = 0; m_boot = 1; m_mis = 0;
         m_scnt = 0; m_fcnt = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (br_taken) begin
         m_pc = br_tgt & 32'hFFFF_FFFC;
         m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 0; m_hold = 0;
         if (br_tgt % 4 != 0) m_mis = 1;
         if (m_fcnt < CMAX) m_fcnt++;
      end else if (stall) begin
         m_hold = 1;
         if (m_scnt < CMAX) m_scnt++;
      end else begin
         m_instr = imem(m_pc);
         m_pc    = m_pc + 32'd4;
         m_pc4   = m_pc;
         m_valid = 1; m_hold = 0;
      end
   end

   // compare every cycle, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc",         pc,                  m_pc);
         chk("ifid_pc4",   ifid_pc4,            m_pc4);
         chk("ifid_instr", ifid_instr,          m_instr);
         chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
         chk("stalled",    {31'b0, stalled},    {31'b0, m_hold});
         chk("misalign",   {31'b0, misalign},   {31'b0, m_mis});
         chk("stall_cnt",  32'(stall_cnt),      32'(m_scnt));
         chk("flush_cnt",  32'(flush_cnt),      32'(m_fcnt));
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic drive(input bit r, input bit s, input bit b, input logic [31:0] t);
      rst = r; stall = s; br_taken = b; br_tgt = t;
   endtask

   initial begin
      drive(1, 0, 0, 32'h0);
      // reset / boot
      tick(2);
      chk_en = 1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
      drive(0, 0, 0, 32'h0);
      tick();
      chk("boot_pc", pc, 32'h0);
      chk("boot_valid", {31'b0, ifid_valid}, 32'h0);
      tick();
      chk("adv1_pc", pc, 32'h4);
      chk("adv1_instr", ifid_instr, 32'h2001_0005);
      chk("adv1_pc4", ifid_pc4, 32'h4);
      chk("adv1_valid", {31'b0, ifid_valid}, 32'h1);
      tick();
      chk("adv2_pc", pc, 32'h8);
      chk("adv2_pc4", ifid_pc4, 32'h8);
      // stall at pc 8 for 3 edges
      drive(0, 1, 0, 32'h0);
      tick(3);
      chk("stall_pc", pc, 32'h8);
      chk("stall_pc4", ifid_pc4, 32'h8);
      chk("stall_flag", {31'b0, stalled}, 32'h1);
      chk("stall_cnt3", 32'(stall_cnt), 32'd3);
      drive(0, 0, 0, 32'h0);
      tick();
      chk("release_pc", pc, 32'hC);
      chk("release_flag", {31'b0, stalled}, 32'h0);
      tick();
      chk("adv4_pc", pc, 32'h10);
      chk("adv4_pc4", ifid_pc4, 32'h10);
      chk("adv4_flush0", 32'(flush_cnt), 32'h0);
      // branch coincident with stall
      drive(0, 1, 1, 32'h0000_0040);
      tick();
      chk("brst_pc", pc, 32'h40);
      chk("brst_valid", {31'b0, ifid_valid}, 32'h0);
      chk("brst_instr", ifid_instr, 32'h0);
      chk("brst_flush", 32'(flush_cnt), 32'd1);
      chk("brst_scnt", 32'(stall_cnt), 32'd3);
      chk("brst_flag", {31'b0, stalled}, 32'h0);
      drive(0, 0, 0, 32'h0);
      tick();
      chk("after_br_pc", pc, 32'h44);
      chk("after_br_instr", ifid_instr, 32'h0040_0013 ^ 32'h00A0_0000);
      // branch out of HOLD
      drive(0, 1, 0, 32'h0);
      tick(2);
      drive(0, 0, 1, 32'h0000_0100);
      tick();
      chk("holdbr_pc", pc, 32'h100);
      chk("holdbr_flag", {31'b0, stalled}, 32'h0);
      chk("holdbr_scnt", 32'(stall_cnt), 32'd5);
      // misaligned target then wrap
      drive(0, 0, 1, 32'hFFFF_FFFE);
      tick();
      chk("mis_pc", pc, 32'hFFFF_FFFC);
      chk("mis_flag", {31'b0, misalign}, 32'h1);
      drive(0, 0, 0, 32'h0);
      tick();
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_pc4", ifid_pc4, 32'h0);
      chk("wrap_mis", {31'b0, misalign}, 32'h1);
      // saturation
      drive(0, 1, 0, 32'h0);
      tick(65537);
      chk("sat_scnt", 32'(stall_cnt), 32'h0000_FFFF);
      // reset mid-stall with a branch pending
      drive(1, 1, 1, 32'h0000_0200);
      tick();
      chk("mrst_pc", pc, 32'h0);
      chk("mrst_scnt", 32'(stall_cnt), 32'h0);
      chk("mrst_fcnt", 32'(flush_cnt), 32'h0);
      chk("mrst_mis", {31'b0, misalign}, 32'h0);
      chk("mrst_flag", {31'b0, stalled}, 32'h0);
      // BOOT ignores branch and stall
      drive(0, 1, 1, 32'h0000_0200);
      tick();
      chk("boot2_pc", pc, 32'h0);
      chk("boot2_valid", {31'b0, ifid_valid}, 32'h0);
      chk("boot2_fcnt", 32'(flush_cnt), 32'h0);
      chk("boot2_scnt", 32'(stall_cnt), 32'h0);
      drive(0, 0, 0, 32'h0);
      tick();
      chk("post_pc", pc, 32'h4);
      chk("post_instr", ifid_instr, 32'h2001_0005);
      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
